// File: rtl/spm_arb_pkg.sv
// Shared types and the round-robin pick helper for the SPM bus arbiter.
package spm_arb_pkg;

  // Widest requester vector the pick helper can scan.
  localparam int unsigned MaxIn     = 32;
  localparam int unsigned MaxInW    = $clog2(MaxIn);
  localparam int unsigned NumInDef  = 4;
  localparam int unsigned IdxWDef   = (NumInDef > 1) ? $clog2(NumInDef) : 1;

  typedef logic [IdxWDef-1:0] idx_t;

  // First set bit of valid[num-1:0] searching upward from ptr with wrap.
  // Returns ptr when nothing is valid so the mux select stays put.
  function automatic int unsigned rr_pick(input logic [MaxIn-1:0] valid,
                                          input int unsigned      num,
                                          input int unsigned      ptr);
    int unsigned pick;
    int unsigned cand;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxIn; k++) begin
      cand = ptr + k;
      if (cand >= num) cand = cand - num;
      if (!found && (k < num) && valid[cand[MaxInW-1:0]]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/spm_arb_id_fifo.sv
// In-order FIFO of requester indices for accepted-but-unanswered SPM requests.
// A push and a pop in the same cycle both take effect and leave count unchanged.
module spm_arb_id_fifo
  import spm_arb_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter type         item_t = idx_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  item_t push_data,
  input  logic  pop,
  output item_t head,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  item_t           mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; count alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spm_bus_rr_arbiter.sv
// N-to-1 round-robin arbiter in front of one SPM bank port. Requests pass
// through combinationally; a stalled request keeps its grant until accepted,
// and responses are routed back in order through an ID FIFO.
module spm_bus_rr_arbiter
  import spm_arb_pkg::*;
#(
  parameter  int unsigned NumIn          = 4,
  parameter  int unsigned AddrWidth      = 32,
  parameter  int unsigned DataWidth      = 64,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned StrbWidth      = DataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumIn*AddrWidth-1:0]     in_addr_i,
  input  logic [NumIn-1:0]               in_we_i,
  input  logic [NumIn*DataWidth-1:0]     in_wdata_i,
  input  logic [NumIn*StrbWidth-1:0]     in_strb_i,
  input  logic [NumIn-1:0]               in_valid_i,
  output logic [NumIn-1:0]               in_ready_o,
  output logic [NumIn-1:0]               in_rvalid_o,
  output logic [NumIn*DataWidth-1:0]     in_rdata_o,
  output logic [AddrWidth-1:0]           out_addr_o,
  output logic                           out_we_o,
  output logic [DataWidth-1:0]           out_wdata_o,
  output logic [StrbWidth-1:0]           out_strb_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  input  logic                           out_rvalid_i,
  input  logic [DataWidth-1:0]           out_rdata_i,
  output logic                           rsp_err_o
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  typedef logic [IdxW-1:0] sel_t;

  sel_t rr_ptr;
  sel_t locked_idx;
  sel_t grant_rr;
  sel_t grant;
  sel_t fifo_head;
  logic lock;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic handshake;

  // Pick the next requester; a held lock overrides the round-robin search.
  always_comb begin
    grant_rr = sel_t'(rr_pick(MaxIn'(in_valid_i), NumIn, 32'(rr_ptr)));
    grant    = lock ? locked_idx : grant_rr;
  end

  // Forward the granted request; a full ID FIFO blocks new acceptances.
  always_comb begin
    out_addr_o  = in_addr_i[grant*AddrWidth +: AddrWidth];
    out_we_o    = in_we_i[grant];
    out_wdata_o = in_wdata_i[grant*DataWidth +: DataWidth];
    out_strb_o  = in_strb_i[grant*StrbWidth +: StrbWidth];
    out_valid_o = in_valid_i[grant] && !fifo_full;
    handshake   = out_valid_o && out_ready_i;
    in_ready_o  = '0;
    if (handshake) in_ready_o[grant] = 1'b1;
  end

  // Route each SPM response to the oldest outstanding requester.
  always_comb begin
    fifo_pop    = out_rvalid_i && !fifo_empty;
    in_rvalid_o = '0;
    if (fifo_pop) in_rvalid_o[fifo_head] = 1'b1;
    in_rdata_o  = {NumIn{out_rdata_i}};
  end

  // Grant lock for stalled requests and round-robin pointer advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock       <= 1'b0;
      locked_idx <= '0;
      rr_ptr     <= '0;
    end else if (handshake) begin
      lock   <= 1'b0;
      rr_ptr <= (grant == sel_t'(NumIn - 1)) ? '0 : grant + 1'b1;
    end else if (out_valid_o) begin
      lock       <= 1'b1;
      locked_idx <= grant;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_err_o <= 1'b0;
    end else if (out_rvalid_i && fifo_empty) begin
      rsp_err_o <= 1'b1;
    end
  end

  spm_arb_id_fifo #(
    .Depth  (MaxOutstanding),
    .item_t (sel_t)
  ) u_id_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (handshake),
    .push_data (grant),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spm_bus_rr_arbiter.sv
// Scoreboard bench for spm_bus_rr_arbiter: the driver runs a queue-based
// reference model and pushes expectations; a negedge monitor pops and compares.
module tb_spm_bus_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N*AW-1:0] in_addr_i;
  logic [N-1:0]    in_we_i;
  logic [N*DW-1:0] in_wdata_i;
  logic [N*SW-1:0] in_strb_i;
  logic [N-1:0]    in_valid_i;
  logic [N-1:0]    in_ready_o;
  logic [N-1:0]    in_rvalid_o;
  logic [N*DW-1:0] in_rdata_o;
  logic [AW-1:0]   out_addr_o;
  logic            out_we_o;
  logic [DW-1:0]   out_wdata_o;
  logic [SW-1:0]   out_strb_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic            out_rvalid_i;
  logic [DW-1:0]   out_rdata_i;
  logic            rsp_err_o;

  always #5 clk_i = ~clk_i;

  spm_bus_rr_arbiter #(
    .NumIn(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_addr_i(in_addr_i), .in_we_i(in_we_i), .in_wdata_i(in_wdata_i),
    .in_strb_i(in_strb_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rvalid_o(in_rvalid_o), .in_rdata_o(in_rdata_o),
    .out_addr_o(out_addr_o), .out_we_o(out_we_o), .out_wdata_o(out_wdata_o),
    .out_strb_o(out_strb_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rvalid_i(out_rvalid_i), .out_rdata_i(out_rdata_i), .rsp_err_o(rsp_err_o)
  );

  typedef struct packed {
    int          idx;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } req_t;

  typedef struct packed {
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct packed {
    logic         ov;
    logic [N-1:0] rdy;
    logic [N-1:0] rv;
    logic         err;
  } cyc_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  cyc_t cyc_q[$];

  int errors = 0;
  int checks = 0;

  // reference model state
  int   m_ptr;
  bit   m_locked;
  int   m_lidx;
  int   m_outq[$];
  bit   m_err;

  logic [AW-1:0] f_addr [N];
  logic          f_we   [N];
  logic [DW-1:0] f_wdata[N];
  logic [SW-1:0] f_strb [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_locked = 0;
    m_lidx   = 0;
    m_outq.delete();
    m_err    = 0;
  endtask

  // One bus cycle: drive inputs, predict the DUT's reaction, queue expectations.
  task automatic step(input logic [N-1:0] v_in, input bit rdy, input bit rv);
    logic [N-1:0] v;
    logic [DW-1:0] rd;
    int   g;
    bit   found, full, ov, hs;
    cyc_t c;
    rsp_t r;
    req_t q;
    v = v_in;
    for (int i = 0; i < N; i++) begin
      if (!(m_locked && m_lidx == i)) begin
        f_addr[i]  = $urandom;
        f_we[i]    = 1'($urandom_range(0, 1));
        f_wdata[i] = {$urandom, $urandom};
        f_strb[i]  = 8'($urandom_range(0, 255));
      end
    end
    if (m_locked) v[m_lidx] = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_addr_i[i*AW +: AW]  = f_addr[i];
      in_we_i[i]             = f_we[i];
      in_wdata_i[i*DW +: DW] = f_wdata[i];
      in_strb_i[i*SW +: SW]  = f_strb[i];
    end
    rd           = {$urandom, $urandom};
    in_valid_i   = v;
    out_ready_i  = rdy;
    out_rvalid_i = rv;
    out_rdata_i  = rd;

    if (m_locked) g = m_lidx;
    else begin
      g = m_ptr;
      found = 0;
      for (int k = 0; k < N; k++)
        if (!found && v[(m_ptr + k) % N]) begin
          g = (m_ptr + k) % N;
          found = 1;
        end
    end
    full = (m_outq.size() == MO);
    ov   = v[g] && !full;
    hs   = ov && rdy;

    c.ov  = ov;
    c.rdy = '0;
    if (hs) c.rdy[g] = 1'b1;
    c.rv  = '0;
    c.err = m_err;

    if (rv) begin
      if (m_outq.size() > 0) begin
        r.idx  = m_outq.pop_front();
        r.data = rd;
        rsp_q.push_back(r);
        c.rv[r.idx] = 1'b1;
      end else begin
        m_err = 1;
      end
    end
    if (hs) begin
      q.idx = g; q.addr = f_addr[g]; q.we = f_we[g]; q.wdata = f_wdata[g]; q.strb = f_strb[g];
      req_q.push_back(q);
      m_outq.push_back(g);
      m_ptr    = (g + 1) % N;
      m_locked = 0;
    end else if (ov) begin
      m_locked = 1;
      m_lidx   = g;
    end
    cyc_q.push_back(c);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < MO + 2 && m_outq.size() > 0; k++) step('0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    in_valid_i   = '0;
    out_ready_i  = 1'b0;
    out_rvalid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_in_ready",  64'(in_ready_o),  64'd0);
    check("reset_in_rvalid", 64'(in_rvalid_o), 64'd0);
    check("reset_rsp_err",   64'(rsp_err_o),   64'd0);
  endtask

  cyc_t mon_c;
  req_t mon_q;
  rsp_t mon_r;
  logic [N-1:0] mon_oh;

  // Monitor: compare everything the DUT presents against queued expectations.
  always @(negedge clk_i) begin
    if (cyc_q.size() > 0) begin
      mon_c = cyc_q.pop_front();
      check("out_valid", 64'(out_valid_o), 64'(mon_c.ov));
      check("in_ready",  64'(in_ready_o),  64'(mon_c.rdy));
      check("in_rvalid", 64'(in_rvalid_o), 64'(mon_c.rv));
      check("rsp_err",   64'(rsp_err_o),   64'(mon_c.err));
      if (out_valid_o && out_ready_i) begin
        check("req_pending", 64'(req_q.size() != 0), 64'd1);
        if (req_q.size() != 0) begin
          mon_q  = req_q.pop_front();
          mon_oh = '0;
          mon_oh[mon_q.idx] = 1'b1;
          check("req_grant", 64'(in_ready_o),  64'(mon_oh));
          check("req_addr",  64'(out_addr_o),  64'(mon_q.addr));
          check("req_we",    64'(out_we_o),    64'(mon_q.we));
          check("req_wdata", out_wdata_o,      mon_q.wdata);
          check("req_strb",  64'(out_strb_o),  64'(mon_q.strb));
        end
      end
      if (in_rvalid_o != '0) begin
        check("rsp_pending", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
          mon_r  = rsp_q.pop_front();
          mon_oh = '0;
          mon_oh[mon_r.idx] = 1'b1;
          check("rsp_route", 64'(in_rvalid_o), 64'(mon_oh));
          for (int i = 0; i < N; i++) check("rsp_rdata", in_rdata_o[i*DW +: DW], mon_r.data);
        end
      end
    end
  end

  initial begin
    in_addr_i = '0; in_we_i = '0; in_wdata_i = '0; in_strb_i = '0;
    in_valid_i = '0; out_ready_i = 1'b0; out_rvalid_i = 1'b0; out_rdata_i = '0;
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    do_reset();

    // all requesting, SPM always ready, response one cycle after acceptance
    for (int k = 0; k < 6; k++) step('1, 1'b1, m_outq.size() > 0);
    drain();

    // stall on requester 2, requester 0 joins during the stall
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    drain();

    // fill the ID FIFO with no responses, then free one slot
    for (int k = 0; k < 7; k++) step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b1);
    step('1, 1'b1, 1'b0);
    // shrink to two outstanding, then push and pop together
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('1, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    drain();

    // randomized traffic with varying response pressure
    for (int k = 0; k < 1500; k++) begin
      int ph;
      bit rv;
      ph = (k / 250) % 3;
      case (ph)
        0:       rv = (m_outq.size() > 0) && ($urandom_range(0, 3) != 0);
        1:       rv = (m_outq.size() > 0) && ($urandom_range(0, 5) == 0);
        default: rv = (m_outq.size() > 0) && ($urandom_range(0, 1) == 0);
      endcase
      step(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 3) != 0, rv);
    end
    drain();

    // response with nothing outstanding
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);

    // reset while locked with three outstanding
    do_reset();
    for (int k = 0; k < 3; k++) step('1, 1'b1, 1'b0);
    step('1, 1'b0, 1'b0);
    do_reset();
    step('1, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);

    check("req_q_left", 64'(req_q.size()), 64'd0);
    check("rsp_q_left", 64'(rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
